multicycle_main_controller: RTL
===============================

// Module: multicycle_main_controller
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core variant. Sequences fetch/decode/execute/
//  memory/writeback over one shared ALU and one unified memory port. Drives alu_op into
//  alu_decoder, and drives the mux selects and write strobes of the datapath. Stalls on a
//  memory ready handshake. Traps illegal opcodes and memory timeouts into a sticky error state.
// PARAMETERS
//  TIMEOUT_CYC  15  consecutive mem_ready=0 cycles in one wait state before error; 0 = no timeout; max 255
//  CNT_W        32  width of the instret counter
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  op          in   7      opcode field from the instruction register
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory completes the current fetch/read/write this cycle
//  pc_write    out  1      PC register enable
//  adr_src     out  1      memory address select: 0=PC, 1=ALUOut
//  mem_write   out  1      memory write strobe
//  ir_write    out  1      instruction register (and OldPC) enable
//  result_src  out  2      result mux: 00=ALUOut, 01=Data, 10=ALUResult
//  alu_src_a   out  2      ALU A mux: 00=PC, 01=OldPC, 10=rs1
//  alu_src_b   out  2      ALU B mux: 00=rs2, 01=ImmExt, 10=4
//  reg_write   out  1      register file write enable
//  alu_op      out  2      to alu_decoder: 00=add, 01=sub, 10=decode funct fields
//  err         out  1      sticky error flag
//  err_code    out  2      01=illegal opcode, 10=memory timeout, 00=none
//  state_o     out  4      current state encoding (debug)
//  instret     out  CNT_W  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  - States (4-bit): RESET=0 FETCH=1 DECODE=2 MEMADR=3 MEMREAD=4 MEMWB=5 MEMWRITE=6 EXECR=7
//    EXECI=8 ALUWB=9 BEQ=10 JAL=11 ERR=12. Codes 13-15 are unused; they go to ERR with err_code=01.
//  - Reset (async, rst_n=0): state=RESET, wait_cnt=0, err=0, err_code=00, instret=0.
//    In RESET every output is 0 except state_o. RESET always moves to FETCH on the next clock.
//  - Outputs are decoded combinationally from the state (Moore). The only Mealy terms are the
//    mem_ready gates and zero, as listed below. Any output not listed for a state is 0.
//  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready.
//    Goes to DECODE when mem_ready=1, otherwise stays in FETCH.
//  - DECODE: a=01, b=01, alu_op=00 (branch/jump target into ALUOut). Next state by op:
//    0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ;
//    1101111 -> JAL. Any other op -> ERR with err_code=01.
//  - MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if op=0000011, otherwise to MEMWRITE.
//  - MEMREAD: adr_src=1. Goes to MEMWB when mem_ready=1.
//  - MEMWB: result_src=01, reg_write=1. Then FETCH.
//  - MEMWRITE: adr_src=1, mem_write=1 held every cycle until mem_ready=1, then FETCH.
//  - EXECR: a=10, b=00, alu_op=10. EXECI: a=10, b=01, alu_op=10. Both go to ALUWB.
//  - ALUWB: result_src=00, reg_write=1. Then FETCH.
//  - BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero. Then FETCH.
//  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Then ALUWB (writes PC+4 to rd).
//  - Latency: R/I-type 4 cycles, beq 3, jal 4, lw 5, sw 4, plus memory stall cycles.
//  - wait_cnt (8 bit): cleared on every state change. Increments each cycle spent in
//    FETCH/MEMREAD/MEMWRITE with mem_ready=0. If TIMEOUT_CYC!=0 and wait_cnt==TIMEOUT_CYC-1
//    with mem_ready=0, the FSM goes to ERR with err_code=10. mem_ready=1 on that same edge
//    wins: the access completes normally.
//  - ERR: all strobes and selects 0. err=1, and err_code keeps its first value.
//    Only rst_n leaves ERR.
//  - Reset asserted mid-instruction: outputs drop to RESET values immediately (async).
//    No partial write strobe survives the reset.
// CONFIGURATION
//  MCC_PERF_CNT_EN defined:
//    - instret increments by 1 on each retiring transition into FETCH: from MEMWB, from
//      MEMWRITE with mem_ready=1, from ALUWB, and from BEQ.
//    - It wraps modulo 2^CNT_W. It does not count in ERR.
//  MCC_PERF_CNT_EN undefined: instret is tied to 0 and no counter flops are built.
// TESTING
//  1. rst_n low 3 cycles, op=0110011, mem_ready=1 -> state_o sequence 0,1,2,7,9,1;
//     reg_write=1 only in ALUWB; alu_op=10 in EXECR.
//  2. lw, mem_ready low 2 cycles in MEMREAD -> 2 extra MEMREAD cycles, then MEMWB with
//     result_src=01 and reg_write=1.
//  3. beq with zero=1, then with zero=0 -> pc_write=1 in BEQ only when zero=1; alu_op=01.
//  4. op=1111111 in DECODE -> ERR, err=1, err_code=01. Holds until rst_n, with all strobes 0.
//  5. TIMEOUT_CYC=4, mem_ready=0 in FETCH -> 4th stalled cycle moves to ERR with err_code=10.
//     Repeat with mem_ready=1 on the 4th cycle -> DECODE, no error.
//  6. MCC_PERF_CNT_EN, CNT_W=4, run 17 R-type instructions -> instret=1 (wrapped).
//     Without the macro, instret=0.

Source files
------------

// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback over one ALU and one memory port.
// Optional retired-instruction counter is built only when MCC_PERF_CNT_EN is defined; otherwise instret is tied to 0.
module multicycle_main_controller #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11,
    S_ERR      = 4'd12
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic [1:0] code_nx;
  logic       in_wait;
  logic       timeout;

  assign state_o = state;
  assign in_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout = (TIMEOUT_CYC != 0) && in_wait && !mem_ready && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        wait_cnt <= 8'd0;
      else if (in_wait && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      // Only the first trap is recorded; ERR is left solely through reset.
      if (state_nx == S_ERR && !err) begin
        err      <= 1'b1;
        err_code <= code_nx;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    code_nx    = 2'b00;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
        else if (timeout) begin
          state_nx = S_ERR;
          code_nx  = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_nx = S_MEMADR;
          7'b0110011:             state_nx = S_EXECR;
          7'b0010011:             state_nx = S_EXECI;
          7'b1100011:             state_nx = S_BEQ;
          7'b1101111:             state_nx = S_JAL;
          default: begin
            state_nx = S_ERR;
            code_nx  = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nx  = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
        else if (timeout) begin
          state_nx = S_ERR;
          code_nx  = 2'b10;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
        else if (timeout) begin
          state_nx = S_ERR;
          code_nx  = 2'b10;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_nx  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_nx  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        state_nx  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nx  = S_ALUWB;
      end
      S_ERR: state_nx = S_ERR;
      default: begin
        state_nx = S_ERR;
        code_nx  = 2'b01;
      end
    endcase
  end

`ifdef MCC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  // An instruction retires on its last transition back into FETCH.
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  (state == S_MEMWRITE && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
